// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default byte width and a pointer-width helper.
package uart_tx_arbiter_pkg;

    localparam int LEN_DATA_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Index width for NUM_REQ requesters, never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// rr_priority_picker: combinational cyclic first-set search starting at rr_ptr,
// returning a one-hot pick (all zeros when req is empty).
module rr_priority_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick
);

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_upper;
    logic [NUM_REQ-1:0] w_src;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_mask
        assign w_mask[g] = (PTR_W'(g) >= rr_ptr);
    end

    // Requests at or above the pointer win; otherwise wrap to the lowest request.
    assign w_upper = req & w_mask;
    assign w_src   = (|w_upper) ? w_upper : req;
    assign pick    = w_src & (-w_src);

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter feeding one UART transmitter.
// Optional tx_done watchdog is built only when UART_TX_ARBITER_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int LEN_DATA       = LEN_DATA_DEFAULT,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           byte_valid,
    input  logic [NUM_REQ*LEN_DATA-1:0]  byte_data,
    input  logic [NUM_REQ-1:0]           byte_last,
    output logic [NUM_REQ-1:0]           byte_ack,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         tx_start,
    output logic [LEN_DATA-1:0]          uart_data_out,
    input  logic                         tx_done,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    state_t              r_state, w_state_next;
    logic [NUM_REQ-1:0]  r_grant, w_grant_next;
    logic [NUM_REQ-1:0]  r_ack, w_ack_next;
    logic [PTR_W-1:0]    r_owner, w_owner_next;
    logic [PTR_W-1:0]    r_rr_ptr, w_rr_ptr_next;
    logic [LEN_DATA-1:0] r_data, w_data_next;
    logic                r_last, w_last_next;
    logic                r_start, w_start_next;

    logic [NUM_REQ-1:0]  w_pick;
    logic [PTR_W-1:0]    w_pick_idx;
    logic [PTR_W-1:0]    w_ptr_after;
    logic                w_owner_valid;
    logic                w_owner_last;
    logic [LEN_DATA-1:0] w_owner_data;
    logic                w_timeout_hit;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .pick   (w_pick)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) w_pick_idx = PTR_W'(i);
        end
    end

    assign w_owner_valid = byte_valid[r_owner];
    assign w_owner_last  = byte_last[r_owner];
    assign w_owner_data  = byte_data[int'(r_owner)*LEN_DATA +: LEN_DATA];
    // With a single requester this wraps to 0 every time, keeping rr_ptr at 0.
    assign w_ptr_after   = (r_owner == PTR_W'(NUM_REQ-1)) ? '0 : r_owner + PTR_W'(1);

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_tout;

    always_ff @(posedge clk) begin
        if (reset || (r_state != WAIT_DONE)) r_wd_cnt <= '0;
        else                                 r_wd_cnt <= r_wd_cnt + CNT_W'(1);
    end

    assign w_timeout_hit = (r_state == WAIT_DONE) && !tx_done &&
                           (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) r_tout <= 1'b0;
        else       r_tout <= w_timeout_hit;
    end

    assign timeout_err = r_tout;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // NOTE: every signal gets its default first so no path through the case infers a latch.
    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_owner_next  = r_owner;
        w_rr_ptr_next = r_rr_ptr;
        w_data_next   = r_data;
        w_last_next   = r_last;
        w_ack_next    = '0;
        w_start_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_grant_next = w_pick;
                    w_owner_next = w_pick_idx;
                    w_state_next = GRANT;
                end
            end
            GRANT: w_state_next = SEND;
            SEND: begin
                if (w_owner_valid) begin
                    w_data_next  = w_owner_data;
                    w_last_next  = w_owner_last;
                    w_ack_next   = r_grant;
                    w_start_next = 1'b1;
                    w_state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if ((tx_done && r_last) || w_timeout_hit) begin
                    w_grant_next  = '0;
                    w_rr_ptr_next = w_ptr_after;
                    w_state_next  = IDLE;
                end else if (tx_done) begin
                    w_state_next = SEND;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_data   <= '0;
            r_last   <= 1'b0;
            r_ack    <= '0;
            r_start  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_grant  <= w_grant_next;
            r_owner  <= w_owner_next;
            r_rr_ptr <= w_rr_ptr_next;
            r_data   <= w_data_next;
            r_last   <= w_last_next;
            r_ack    <= w_ack_next;
            r_start  <= w_start_next;
        end
    end

    assign grant         = r_grant;
    assign byte_ack      = r_ack;
    assign tx_start      = r_start;
    assign uart_data_out = r_data;
    assign busy          = (r_state != IDLE);

endmodule
